// File: rtl/ysyx_22050078_ifu_pkg.sv
// Shared IFU definitions: datapath width, FSM encodings and the default fetch queue depth.
package ysyx_22050078_ifu_pkg;
    localparam int CPU_WIDTH    = 32;
    localparam int FQ_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IFU_ST_REQ  = 2'd0,
        IFU_ST_WAIT = 2'd1,
        IFU_ST_DROP = 2'd2
    } ifu_st_e;
endpackage

// File: rtl/ysyx_22050078_ifq.sv
// Circular fetch queue with push/pop/flush; exposes its occupancy for the IFU credit check.
module ysyx_22050078_ifq #(
    parameter int DEPTH = 2,
    parameter int DW    = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          gclk,
    input  logic          grst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head_data
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          pop_ok;

    assign pop_ok    = pop & (count != '0);
    assign head_data = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push)   wptr <= wptr + PW'(1);
            if (pop_ok) rptr <= rptr + PW'(1);
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge gclk) begin
        if (push) mem[wptr] <= push_data;
    end
endmodule

// File: rtl/ysyx_22050078_ifu.sv
// Instruction fetch unit: single outstanding imem request, wrong-path drop on flush, fetch queue to IDU.
module ysyx_22050078_ifu
    import ysyx_22050078_ifu_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DEF,
    parameter int INST_W   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic                 i_flush,
    output logic                 o_pcwen,
    output logic                 o_imem_req_valid,
    input  logic                 i_imem_req_ready,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_rsp_valid,
    input  logic [INST_W-1:0]    i_imem_rsp_data,
    output logic                 o_id_valid,
    input  logic                 i_id_ready,
    output logic [INST_W-1:0]    o_id_inst,
    output logic [CPU_WIDTH-1:0] o_id_pc
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    ifu_st_e                     state, state_nxt;
    logic [CPU_WIDTH-1:0]        pend_pc;
    logic [CW-1:0]               count;
    logic                        fire, push;
    logic [INST_W+CPU_WIDTH-1:0] head;

    // Only request when a queue slot is guaranteed for the response.
    assign o_imem_req_valid = i_rst_n & (state == IFU_ST_REQ) & (count < CW'(FQ_DEPTH)) & ~i_flush;
    assign fire             = o_imem_req_valid & i_imem_req_ready;
    assign o_pcwen          = i_rst_n & (fire | i_flush);
    assign o_imem_addr      = i_pc;
    assign o_id_valid       = (count != '0);
    assign {o_id_inst, o_id_pc} = head;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IFU_ST_REQ:  if (fire) state_nxt = IFU_ST_WAIT;
            IFU_ST_WAIT: begin
                if (i_imem_rsp_valid) begin
                    push      = ~i_flush;
                    state_nxt = IFU_ST_REQ;
                end else if (i_flush) begin
                    state_nxt = IFU_ST_DROP;
                end
            end
            IFU_ST_DROP: if (i_imem_rsp_valid) state_nxt = IFU_ST_REQ;
            default:     state_nxt = IFU_ST_REQ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IFU_ST_REQ;
            pend_pc <= '0;
        end else begin
            state <= state_nxt;
            if (fire) pend_pc <= i_pc;
        end
    end

    ysyx_22050078_ifq #(
        .DEPTH (FQ_DEPTH),
        .DW    (INST_W + CPU_WIDTH)
    ) u_ifq (
        .gclk      (i_clk),
        .grst_n    (i_rst_n),
        .push      (push),
        .push_data ({i_imem_rsp_data, pend_pc}),
        .pop       (o_id_valid & i_id_ready),
        .flush     (i_flush),
        .count     (count),
        .head_data (head)
    );
endmodule

// File: tb/tb_ysyx_22050078_ifu.sv
// Directed bench for the IFU: BRU PC model, scripted imem responder, scoreboard on IDU pops.
module tb_ysyx_22050078_ifu;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_pcwen;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b1;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        o_id_valid;
    logic        i_id_ready = 1'b0;
    logic [31:0] o_id_inst;
    logic [31:0] o_id_pc;
    logic [31:0] bru_pc;
    logic [31:0] jump_pc = '0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t exp_q[$];

    int    total = 0;
    int    bad = 0;
    int    pcwen_cnt = 0;
    bit    auto_rsp = 1'b1;
    logic  fire_s = 1'b0;
    logic [31:0] addr_s = '0;

    always #5 i_clk = ~i_clk;

    // BRU PC register: sequential advance on fetch, jump target on flush.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     bru_pc <= 32'h8000_0000;
        else if (o_pcwen) bru_pc <= i_flush ? jump_pc : bru_pc + 32'd4;
    end

    ysyx_22050078_ifu dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_pc             (bru_pc),
        .i_flush          (i_flush),
        .o_pcwen          (o_pcwen),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_id_valid       (o_id_valid),
        .i_id_ready       (i_id_ready),
        .o_id_inst        (o_id_inst),
        .o_id_pc          (o_id_pc)
    );

    function automatic logic [31:0] inst_at(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0013;
            32'h8000_0004: return 32'h0010_0093;
            32'h8000_0008: return 32'h0020_0113;
            32'h8000_000C: return 32'h0030_0193;
            32'hA000_0000: return 32'h0060_0313;
            32'hA000_0004: return 32'h0070_0393;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic half_n;
        @(negedge i_clk);
        fire_s = o_imem_req_valid & i_imem_req_ready;
        addr_s = o_imem_addr;
        if (i_rst_n && o_pcwen) pcwen_cnt++;
    endtask

    // In auto mode the memory answers exactly one cycle after the request fires.
    task automatic half_p;
        @(posedge i_clk);
        #1;
        if (auto_rsp) begin
            i_imem_rsp_valid = fire_s;
            i_imem_rsp_data  = fire_s ? inst_at(addr_s) : 32'h0;
        end
    endtask

    task automatic tick;
        half_n;
        half_p;
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_id_valid && i_id_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc %h want no pop", o_id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst", o_id_inst, e.inst);
                    chk("sb_pc", o_id_pc, e.pc);
                end
            end
        end
    end

    initial begin : stim
        // Reset: outputs forced low even with memory ready.
        repeat (2) tick;
        half_n;
        chk("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        chk("rst_pcwen", {31'd0, o_pcwen}, 32'd0);
        chk("rst_id_valid", {31'd0, o_id_valid}, 32'd0);
        half_p;
        i_rst_n = 1'b1;

        // First fetch, then fill the queue with IDU stalled.
        half_n;
        chk("f1_req_valid", {31'd0, o_imem_req_valid}, 32'd1);
        chk("f1_addr", o_imem_addr, 32'h8000_0000);
        chk("f1_pcwen", {31'd0, o_pcwen}, 32'd1);
        half_p;
        half_n;
        chk("f1_wait_pcwen", {31'd0, o_pcwen}, 32'd0);
        chk("f1_no_bypass", {31'd0, o_id_valid}, 32'd0);
        half_p;
        half_n;
        chk("f1_id_valid", {31'd0, o_id_valid}, 32'd1);
        chk("f1_id_inst", o_id_inst, 32'h0000_0013);
        chk("f1_id_pc", o_id_pc, 32'h8000_0000);
        half_p;
        tick;
        for (int i = 0; i < 3; i++) begin
            half_n;
            chk("full_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
            if (i == 0) chk("pcwen_pulses", pcwen_cnt, 32'd2);
            half_p;
        end

        // Drain in order while one more fetch completes.
        exp_q.push_back('{inst: 32'h0000_0013, pc: 32'h8000_0000});
        exp_q.push_back('{inst: 32'h0010_0093, pc: 32'h8000_0004});
        exp_q.push_back('{inst: 32'h0020_0113, pc: 32'h8000_0008});
        i_id_ready = 1'b1;
        repeat (3) tick;

        // Memory not ready: request held stable, no PC write.
        i_imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            half_n;
            chk("stall_req_valid", {31'd0, o_imem_req_valid}, 32'd1);
            chk("stall_addr", o_imem_addr, 32'h8000_000C);
            chk("stall_pcwen", {31'd0, o_pcwen}, 32'd0);
            half_p;
        end

        // Flush in WAIT; late response 3 cycles after the flush is dropped.
        auto_rsp = 1'b0;
        i_imem_req_ready = 1'b1;
        half_n;
        chk("w_fire_pcwen", {31'd0, o_pcwen}, 32'd1);
        half_p;
        i_flush = 1'b1;
        jump_pc = 32'h9000_0000;
        half_n;
        chk("w_flush_pcwen", {31'd0, o_pcwen}, 32'd1);
        chk("w_flush_req", {31'd0, o_imem_req_valid}, 32'd0);
        half_p;
        i_flush = 1'b0;
        half_n;
        chk("drop_id_valid", {31'd0, o_id_valid}, 32'd0);
        chk("drop_req", {31'd0, o_imem_req_valid}, 32'd0);
        half_p;
        tick;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'hDEAD_BEEF;
        half_n;
        chk("drop_rsp_req", {31'd0, o_imem_req_valid}, 32'd0);
        chk("drop_rsp_pcwen", {31'd0, o_pcwen}, 32'd0);
        half_p;
        i_imem_rsp_valid = 1'b0;
        half_n;
        chk("post_drop_id_valid", {31'd0, o_id_valid}, 32'd0);
        chk("post_drop_req", {31'd0, o_imem_req_valid}, 32'd1);
        chk("jump_addr", o_imem_addr, 32'h9000_0000);
        half_p;

        // Flush coinciding with a response while the queue holds one entry.
        i_id_ready = 1'b0;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'h0040_0213;
        tick;
        i_imem_rsp_valid = 1'b0;
        half_n;
        chk("q1_id_valid", {31'd0, o_id_valid}, 32'd1);
        chk("q1_inst", o_id_inst, 32'h0040_0213);
        chk("q1_pc", o_id_pc, 32'h9000_0000);
        half_p;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'h0050_0293;
        i_flush = 1'b1;
        jump_pc = 32'hA000_0000;
        half_n;
        chk("fr_pcwen", {31'd0, o_pcwen}, 32'd1);
        half_p;
        i_flush = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_req_ready = 1'b0;
        half_n;
        chk("fr_id_valid", {31'd0, o_id_valid}, 32'd0);
        chk("fr_in_req", {31'd0, o_imem_req_valid}, 32'd1);
        chk("fr_addr", o_imem_addr, 32'hA000_0000);
        half_p;

        // Push and pop in the same cycle with one entry queued.
        exp_q.push_back('{inst: 32'h0060_0313, pc: 32'hA000_0000});
        exp_q.push_back('{inst: 32'h0070_0393, pc: 32'hA000_0004});
        i_imem_req_ready = 1'b1;
        auto_rsp = 1'b1;
        repeat (3) tick;
        i_id_ready = 1'b1;
        tick;
        i_imem_req_ready = 1'b0;
        half_n;
        chk("pp_id_valid", {31'd0, o_id_valid}, 32'd1);
        chk("pp_head_pc", o_id_pc, 32'hA000_0004);
        chk("pp_head_inst", o_id_inst, 32'h0070_0393);
        chk("pp_not_full", {31'd0, o_imem_req_valid}, 32'd1);
        half_p;
        half_n;
        chk("pp_empty", {31'd0, o_id_valid}, 32'd0);
        half_p;
        repeat (2) tick;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22050078_ifu.md
# ysyx_22050078_ifu

Instruction fetch unit sitting directly upstream of the branch/PC unit's consumers. It takes the current PC from the BRU PC register and issues one instruction-memory request at a time. It buffers returned instructions in a 2-entry fetch queue that feeds the IF/ID boundary, and drives the BRU's `i_pcwen`. The BRU's `o_if2id_bubble` arrives here as `i_flush`; it kills wrong-path fetches and empties the queue.

## Interface
Parameters:
- `FQ_DEPTH`, default 2: fetch queue entries; must be a power of two and at least 2.
- `INST_W`, default 32: instruction width.

Ports:
- `i_clk`  in  1  core clock
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_pc`  in  `CPU_WIDTH`  current PC from BRU
- `i_flush`  in  1  redirect from BRU (`o_if2id_bubble`)
- `o_pcwen`  out  1  BRU PC write enable
- `o_imem_req_valid`  out  1  fetch request
- `i_imem_req_ready`  in  1  memory accepts request
- `o_imem_addr`  out  `CPU_WIDTH`  fetch address
- `i_imem_rsp_valid`  in  1  response strobe
- `i_imem_rsp_data`  in  `INST_W`  fetched instruction
- `o_id_valid`  out  1  queue head valid to IDU
- `i_id_ready`  in  1  IDU consumes head
- `o_id_inst`  out  `INST_W`  head instruction
- `o_id_pc`  out  `CPU_WIDTH`  head PC

## Operation
- FSM has three states:
  - REQ: no request outstanding.
  - WAIT: one request accepted, response pending.
  - DROP: the outstanding response is wrong-path and will be discarded.
- REQ behaviour:
  - `o_imem_req_valid = (count < FQ_DEPTH) & ~i_flush`.
  - `o_imem_addr = i_pc`.
  - Fire (`valid & ready`) latches `i_pc` into `pend_pc` and moves to WAIT.
  - Valid is held until ready.
  - `i_pc` is stable while waiting, because `o_pcwen` is 0.
- WAIT behaviour:
  - On `i_imem_rsp_valid`, push {`rsp_data`, `pend_pc`} and go to REQ.
  - `i_flush` without a response goes to DROP.
  - `i_flush` with a response discards the response and goes to REQ.
- DROP behaviour:
  - `i_imem_rsp_valid` discards the response and goes to REQ.
  - `i_flush` keeps the state in DROP.
- `o_pcwen = fire | i_flush`:
  - fire advances the BRU to `seq_pc`;
  - flush loads `jump_pc`.
  - Fire and flush never coincide, because flush gates `req_valid`.
- Fetch queue:
  - Circular buffer with `count` held in `$clog2(FQ_DEPTH)+1` bits; pointers wrap modulo `FQ_DEPTH`.
  - Pop occurs on `o_id_valid & i_id_ready`.
  - Simultaneous push and pop leaves `count` unchanged.
  - Push never occurs when full, because the credit check in REQ guarantees space.
  - `i_flush` clears `count` and both pointers in the same edge, overriding any push or pop.
  - `o_id_valid = (count != 0)`; `o_id_inst`/`o_id_pc` come from the head entry.

## Timing
- Reset values:
  - State REQ, `count` 0, pointers 0, `pend_pc` 0.
  - `o_id_valid` 0.
  - `o_imem_req_valid` and `o_pcwen` forced 0 while `i_rst_n` is low.
- Reset mid-operation abandons any outstanding request. A late response arriving after reset release while in REQ is ignored.
- Latency:
  - Request fire at cycle t; response at the earliest in t+1.
  - Instruction visible on `o_id_valid` at the cycle after the response.
  - No bypass path.
- Throughput: at most one fetch per 2 cycles (REQ→WAIT→REQ).
- `i_flush` at cycle t: `o_id_valid` is 0 at t+1, and the first new-path request is issued no earlier than t+1.
- `i_id_ready` while `o_id_valid` is 0 is ignored.

## Structure
- Add state encodings `IFU_ST_REQ`/`IFU_ST_WAIT`/`IFU_ST_DROP` (2 bits) and `FQ_DEPTH` default to the shared `defines.v`. Width comes from the existing `CPU_WIDTH`.
- One sub-module, `ysyx_22050078_ifq`:
  - Parameterised FIFO with push/pop/flush, data `INST_W+CPU_WIDTH`.
  - Exposes `count`.
- The PC register stays in the BRU; this block holds no architectural PC.

## Test plan
- Reset, `i_pc`=0x80000000, memory ready and responding 1 cycle later with 0x00000013 → `o_id_valid`=1 with inst 0x00000013 and pc 0x80000000. `o_pcwen` pulses exactly once per fetch.
- `i_id_ready`=0 held → after 2 fetches (count=2) `o_imem_req_valid` stays 0. Raising ready resumes fetching, and entries drain in order 0x80000000, 0x80000004.
- `i_imem_req_ready`=0 for 5 cycles → req_valid and addr held stable, `o_pcwen`=0 throughout.
- Flush while in WAIT, response 3 cycles later with 0xDEADBEEF → response discarded, `o_id_valid`=0, next request addr equals the BRU jump target.
- Flush in the same cycle as the response, with the queue holding 1 entry → queue empty next cycle, response dropped, FSM in REQ.
- Simultaneous push and pop with count=1 → count remains 1, and the head advances to the newly pushed PC.
